// File: rtl/emmc_rx_pkg.sv
// Shared types and constants for the eMMC DDR 4-bit DAT-line receiver.
// Holds the receiver state encoding and the CRC16-CCITT single-bit step.
package emmc_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC        = 3'd3,
    ST_END_BIT    = 3'd4
  } rx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One MSB-first shift of x^16+x^12+x^5+1.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC16-CCITT engine, init 0, MSB first.
// Clear has priority over shift; state holds when neither is asserted.
module crc16_serial
  import emmc_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC state
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 16'h0000;
    end else if (shift) begin
      crc_d = crc16_step(crc_q, din);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/emmc_ddr_dat_rx.sv
// eMMC DDR 4-bit DAT-line block receiver: start-bit search with timeout, byte
// delivery straight from the IDDR outputs, per-line/per-edge CRC16 check, end bit.
module emmc_ddr_dat_rx
  import emmc_rx_pkg::*;
#(
  parameter int TO_W  = 16,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       dat_rise,
  input  logic [3:0]       dat_fall,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [TO_W-1:0]  to_limit,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             crc_err,
  output logic             end_err,
  output logic             timeout,
  output logic             busy
);

  localparam logic [LEN_W:0]  BYTE_LAST = (LEN_W+1)'(1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(1);

  rx_state_e        state_q, state_d;
  logic [LEN_W:0]   byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic             crc_bad_q, crc_bad_d;

  logic             start_bit;
  logic             crc_clr;
  logic             crc_shift;
  logic             crc_mismatch;
  logic             residue_nz;
  logic [3:0]       rise_msb, fall_msb;
  logic [3:0]       rise_res, fall_res;

  assign start_bit = (dat_rise == 4'h0);
  assign crc_clr   = (state_q == ST_IDLE) && start;
  assign crc_shift = (state_q == ST_DATA) || (state_q == ST_CRC);

  // Received CRC bits are fed into the engines too, so a clean block leaves a
  // zero residue that cross-checks the per-bit compare.
  for (genvar n = 0; n < 4; n++) begin : g_line
    logic [15:0] rise_crc;
    logic [15:0] fall_crc;

    crc16_serial u_rise (
      .clk   (clk),
      .rst   (rst),
      .clr   (crc_clr),
      .shift (crc_shift),
      .din   (dat_rise[n]),
      .crc   (rise_crc)
    );

    crc16_serial u_fall (
      .clk   (clk),
      .rst   (rst),
      .clr   (crc_clr),
      .shift (crc_shift),
      .din   (dat_fall[n]),
      .crc   (fall_crc)
    );

    assign rise_msb[n] = rise_crc[15];
    assign fall_msb[n] = fall_crc[15];
    assign rise_res[n] = |rise_crc;
    assign fall_res[n] = |fall_crc;
  end

  assign crc_mismatch = |((dat_rise ^ rise_msb) | (dat_fall ^ fall_msb));
  assign residue_nz   = |{rise_res, fall_res};

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= {(LEN_W+1){1'b0}};
      to_cnt_q   <= {TO_W{1'b0}};
      crc_cnt_q  <= 4'h0;
      crc_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      crc_bad_q  <= crc_bad_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_START;
        else       state_d = ST_IDLE;
      end
      ST_WAIT_START: begin
        if (start_bit)                 state_d = ST_DATA;
        else if (to_cnt_q <= TO_LAST)  state_d = ST_IDLE;
        else                           state_d = ST_WAIT_START;
      end
      ST_DATA: begin
        if (byte_cnt_q == BYTE_LAST) state_d = ST_CRC;
        else                         state_d = ST_DATA;
      end
      ST_CRC: begin
        if (crc_cnt_q == 4'hF) state_d = ST_END_BIT;
        else                   state_d = ST_CRC;
      end
      ST_END_BIT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counter and sticky-error updates; blk_len of zero loads 2^LEN_W
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    crc_bad_d  = crc_bad_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          byte_cnt_d = {(blk_len == {LEN_W{1'b0}}), blk_len};
          to_cnt_d   = to_limit;
          crc_cnt_d  = 4'h0;
          crc_bad_d  = 1'b0;
        end else begin
          crc_bad_d  = crc_bad_q;
        end
      end
      ST_WAIT_START: begin
        if (!start_bit) to_cnt_d = to_cnt_q - TO_LAST;
        else            to_cnt_d = to_cnt_q;
      end
      ST_DATA: byte_cnt_d = byte_cnt_q - BYTE_LAST;
      ST_CRC: begin
        crc_cnt_d = crc_cnt_q + 4'h1;
        crc_bad_d = crc_bad_q | crc_mismatch;
      end
      default: crc_bad_d = crc_bad_q;
    endcase
  end

  // Outputs: bytes pass through with no added latency; done/flags are Mealy
  // on the final cycle so nothing leaks out while rst is asserted
  always_comb begin
    rx_valid = (state_q == ST_DATA) && !rst;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    crc_err  = 1'b0;
    end_err  = 1'b0;
    timeout  = 1'b0;
    if (rx_valid) rx_data = {dat_rise, dat_fall};
    else          rx_data = 8'h00;
    case (state_q)
      ST_WAIT_START: begin
        if (!start_bit && (to_cnt_q <= TO_LAST) && !rst) begin
          done    = 1'b1;
          timeout = 1'b1;
        end else begin
          done    = 1'b0;
        end
      end
      ST_END_BIT: begin
        if (!rst) begin
          done    = 1'b1;
          end_err = (dat_rise != 4'hF);
          crc_err = crc_bad_q | residue_nz;
        end else begin
          done    = 1'b0;
        end
      end
      default: done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_emmc_ddr_dat_rx.sv
// Directed + randomized bench for emmc_ddr_dat_rx; the reference computes each
// of the 8 CRC16s arithmetically over the bytes sent and predicts bytes/flags.
module tb_emmc_ddr_dat_rx;

  localparam int TO_W  = 16;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       dat_rise;
  logic [3:0]       dat_fall;
  logic             start;
  logic [LEN_W-1:0] blk_len;
  logic [TO_W-1:0]  to_limit;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             done;
  logic             crc_err;
  logic             end_err;
  logic             timeout;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got_q[$];
  int         done_cnt;
  logic [2:0] done_flags;
  logic [7:0] tx [0:15];

  emmc_ddr_dat_rx #(.TO_W(TO_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .dat_rise (dat_rise),
    .dat_fall (dat_fall),
    .start    (start),
    .blk_len  (blk_len),
    .to_limit (to_limit),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .done     (done),
    .crc_err  (crc_err),
    .end_err  (end_err),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples mid-cycle, then advances to 1 time unit after the next rising edge.
  task automatic tick();
    #3;
    if (rx_valid === 1'b1) got_q.push_back(rx_data);
    else check("rx_data_idle", 32'(rx_data), 32'h0);
    if (done === 1'b1) begin
      done_cnt++;
      done_flags = {crc_err, end_err, timeout};
    end else begin
      check("flags_quiet", 32'({crc_err, end_err, timeout}), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // CRC16-CCITT (init 0, MSB first) over bit 'pos' of tx[0..nbytes-1].
  function automatic logic [15:0] ref_crc(input int nbytes, input int pos);
    logic [31:0] c;
    logic [31:0] b;
    logic [31:0] fb;
    c = 32'h0;
    for (int k = 0; k < nbytes; k++) begin
      b  = (32'(tx[k]) >> pos) & 32'h1;
      fb = ((c >> 15) & 32'h1) ^ b;
      c  = ((c << 1) & 32'hFFFF) ^ ((fb != 32'h0) ? 32'h1021 : 32'h0);
    end
    return c[15:0];
  endfunction

  task automatic run_block(input string tag, input int len_field, input int nbytes,
                           input int to_lim, input int pre, input int flip_bit,
                           input int flip_cyc, input logic [3:0] end_nib, input int restart_at);
    logic [15:0] crcs [8];
    logic [7:0]  b;
    got_q.delete();
    done_cnt   = 0;
    done_flags = 3'b000;
    for (int e = 0; e < 8; e++) crcs[e] = ref_crc(nbytes, e);
    if (flip_bit >= 0) crcs[flip_bit][15-flip_cyc] = ~crcs[flip_bit][15-flip_cyc];
    blk_len  = LEN_W'(len_field);
    to_limit = TO_W'(to_lim);
    start    = 1'b1;
    dat_rise = 4'hF;
    dat_fall = 4'($urandom);
    tick();
    start = 1'b0;
    check({tag, "_busy_armed"}, 32'(busy), 32'h1);
    for (int p = 0; p < pre; p++) begin
      dat_rise = 4'hF;
      dat_fall = 4'($urandom);
      tick();
    end
    dat_rise = 4'h0;
    dat_fall = 4'($urandom);
    tick();
    for (int k = 0; k < nbytes; k++) begin
      {dat_rise, dat_fall} = tx[k];
      start = (k == restart_at);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int e = 0; e < 8; e++) b[e] = crcs[e][15-i];
      {dat_rise, dat_fall} = b;
      tick();
    end
    dat_rise = end_nib;
    dat_fall = 4'($urandom);
    tick();
    dat_rise = 4'hF;
    tick();
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(nbytes));
    for (int k = 0; k < nbytes && k < got_q.size(); k++)
      check({tag, "_byte"}, 32'(got_q[k]), 32'(tx[k]));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'h1);
    check({tag, "_flags"}, 32'(done_flags),
          32'({(flip_bit >= 0), (end_nib != 4'hF), 1'b0}));
    check({tag, "_busy_after"}, 32'(busy), 32'h0);
  endtask

  task automatic run_timeout(input string tag, input int to_lim);
    int n;
    got_q.delete();
    done_cnt   = 0;
    done_flags = 3'b000;
    to_limit   = TO_W'(to_lim);
    blk_len    = LEN_W'(3);
    start      = 1'b1;
    dat_rise   = 4'hF;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 40) begin
      dat_fall = 4'($urandom);
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(to_lim));
    check({tag, "_flags"}, 32'(done_flags), 32'h1);
    check({tag, "_no_bytes"}, 32'(got_q.size()), 32'h0);
    check({tag, "_busy_after"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int nb;
    int tl;
    // Reset with start held high: start must not be taken.
    rst      = 1'b1;
    start    = 1'b1;
    dat_rise = 4'hF;
    dat_fall = 4'h0;
    blk_len  = LEN_W'(3);
    to_limit = TO_W'(7);
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_flags", 32'({done, crc_err, end_err, timeout}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    tx[0] = 8'hA5; tx[1] = 8'h3C; tx[2] = 8'hFF; tx[3] = 8'h00;
    run_block("good4", 4, 4, 10, 2, -1, 0, 4'hF, -1);
    // Fall-edge DAT2 is byte bit 2; CRC bit 7 goes out on CRC cycle 8.
    run_block("crcflip", 4, 4, 10, 2, 2, 8, 4'hF, -1);
    run_timeout("to5", 5);

    tx[0] = 8'($urandom); tx[1] = 8'($urandom);
    run_block("enderr", 2, 2, 10, 1, -1, 0, 4'h7, -1);

    // Reset during byte 2 of a 4-byte block, with start also high.
    for (int k = 0; k < 4; k++) tx[k] = 8'($urandom);
    got_q.delete();
    done_cnt = 0;
    blk_len  = LEN_W'(4);
    to_limit = TO_W'(10);
    start    = 1'b1;
    dat_rise = 4'hF;
    tick();
    start    = 1'b0;
    dat_rise = 4'h0;
    tick();
    {dat_rise, dat_fall} = tx[0];
    tick();
    {dat_rise, dat_fall} = tx[1];
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    dat_rise = 4'hF;
    tick();
    tick();
    check("abort_done", 32'(done_cnt), 32'h0);
    check("abort_bytes", 32'(got_q.size()), 32'h1);
    check("abort_idle", 32'(busy), 32'h0);
    run_block("after_abort", 4, 4, 10, 0, -1, 0, 4'hF, -1);

    for (int k = 0; k < 16; k++) tx[k] = 8'($urandom);
    run_block("len0", 0, 16, 10, 3, -1, 0, 4'hF, 5);

    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 15);
      tl = $urandom_range(3, 12);
      for (int k = 0; k < nb; k++) tx[k] = 8'($urandom);
      run_block("rand", nb, nb, tl, $urandom_range(0, tl - 1),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1,
                $urandom_range(0, 15),
                ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), -1);
    end
    for (int r = 0; r < 2; r++) run_timeout("rand_to", $urandom_range(2, 9));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
